instruction_fetch_controller: RTL and testbench
===============================================

Name: instruction_fetch_controller

Overview:
- Sequences the combinational instruction_memory. Owns the PC, drives the memory address, and captures each returned 32-bit word into a small FIFO.
- Presents fetched instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects, which flush the FIFO, plus halt/resume and misaligned-target faults.
- Sits between the PC logic and the decode stage of the datapath.

Parameters:
RESET_PC, 64'h0, PC loaded on reset.
PC_STEP, 4, byte increment per sequential fetch.
DEPTH, 2, FIFO entries (power of two, ≥2).

Ports:
CLK  input  1  clock, all state updates on posedge.
RST  input  1  synchronous, active-high reset.
IMEM_ADDR  output  64  address to instruction_memory ADDR.
IMEM_DATA  input  32  instruction_memory OUTPUT, valid in the same cycle.
INSTR_VALID  output  1  FIFO head holds a valid instruction.
INSTR_READY  input  1  decode accepts the head.
INSTR  output  32  head instruction word.
INSTR_PC  output  64  PC of the head instruction.
REDIRECT_VALID  input  1  taken branch or jump.
REDIRECT_PC  input  64  redirect target.
HALT_REQ  input  1  stop fetching.
RESUME  input  1  leave HALT and restart at the current PC.
HALTED  output  1  state is HALT and the FIFO is empty.
FAULT  output  1  misaligned redirect target seen (sticky).

Behaviour:
- Reset (RST=1 at posedge): PC=RESET_PC, FIFO empty, state=RUN, FAULT=0.
  - Outputs after reset: INSTR_VALID=0, INSTR=0, INSTR_PC=0, HALTED=0.
  - IMEM_ADDR=RESET_PC.
  - Reset mid-operation discards all FIFO contents and any pending redirect.
- States:
  - RUN: fetching enabled.
  - HALT: no fetch; FIFO drains normally.
  - FAULT_HALT: no fetch; only RST exits.
- IMEM_ADDR always equals PC (combinational from the register).
- fetch = (state==RUN) && !REDIRECT_VALID && (count<DEPTH || pop).
  - pop = INSTR_VALID && INSTR_READY.
- On fetch: push {IMEM_DATA, PC} at posedge; PC <= PC+PC_STEP (64-bit modular, wraps at 2^64).
- Latency: the instruction at PC appears on INSTR the cycle after it is addressed. With READY held high, throughput is one instruction per cycle.
- Full FIFO with pop in the same cycle: push and pop both occur, count unchanged.
- Full FIFO without pop: no fetch, PC holds.
- INSTR/INSTR_PC are stable while INSTR_VALID=1 and INSTR_READY=0.
- When empty, INSTR/INSTR_PC hold their last value and are don't-care.
- REDIRECT_VALID=1 at posedge (highest priority after RST):
  - FIFO flushed (count=0), no push that cycle.
  - Any same-cycle pop is still considered consumed by decode.
  - If REDIRECT_PC[1:0]==0: PC<=REDIRECT_PC and the state is unchanged (RUN stays RUN, HALT stays HALT).
  - Else: FAULT<=1, state<=FAULT_HALT, PC unchanged.
- HALT_REQ in RUN: state<=HALT; no fetch in that cycle.
- RESUME in HALT: state<=RUN and fetch resumes at PC the next cycle.
  - RESUME and HALT_REQ together: HALT_REQ wins.
  - RESUME outside HALT is ignored.
- HALTED = (state!=RUN) && count==0.

Decomposition:
- Shared package `fetch_pkg`:
  - State encoding constants (RUN=2'd0, HALT=2'd1, FAULT_HALT=2'd2).
  - XLEN=64 and ILEN=32 constants.
- Sub-module `fetch_fifo`: parameterised DEPTH circular buffer.
  - Ports: push, pop, flush, din {instr, pc}, dout, count.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- The top level holds the PC register, FSM and fetch logic, and instantiates instruction_memory only in the bench.

Test Plan:
1. Reset then READY=1 with memory word[i]=i+1: INSTR_VALID rises 1 cycle after reset release; INSTR = 1,2,3,… with INSTR_PC = 0,4,8,…, one per cycle.
2. READY=0 for 5 cycles: after 2 fetches the FIFO is full and PC holds at 8; INSTR stays at PC 0. Raising READY then delivers PC 0, 4, 8 in consecutive cycles with no gaps or duplicates.
3. REDIRECT_VALID with REDIRECT_PC=0x40 while the FIFO holds 2 entries: next cycle INSTR_VALID=0 and IMEM_ADDR=0x40; the following cycle INSTR_PC=0x40.
4. REDIRECT_PC=0x42: FAULT=1, fetching stops, FIFO empty, HALTED=1, PC unchanged. Only RST clears the fault, after which PC=RESET_PC.
5. HALT_REQ at PC=0x10 with READY=1: remaining entries drain, HALTED asserts, IMEM_ADDR stays at the PC where fetch stopped. RESUME restarts delivery from that PC without losing or repeating an instruction.
6. RST asserted mid-stream with the FIFO full: next cycle INSTR_VALID=0, IMEM_ADDR=RESET_PC, FAULT=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Types and constants shared by the instruction fetch controller and its
//   FIFO.
//     XLEN          : address / PC width
//     ILEN          : instruction word width
//     fetch_state_e : fetch FSM states (RUN, HALT, FAULT_HALT)
//     fetch_entry_t : one FIFO entry, an instruction word plus its PC
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_HALT       = 2'd1,
      ST_FAULT_HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Circular buffer of DEPTH fetch entries. DEPTH must be a power of two, so
//   the pointers wrap on their own.
//   Ports:
//     clk_i   : clock
//     rst_i   : synchronous active-high reset (empties and zeroes the buffer)
//     push_i  : write din_i at the tail (ignored when full without a pop)
//     pop_i   : drop the head entry (ignored when empty)
//     flush_i : discard all entries; takes priority over push/pop
//     din_i   : entry to write
//     dout_o  : head entry (don't-care when count_o == 0)
//     count_o : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  fetch_entry_t  din_i,
   output fetch_entry_t  dout_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   // A full buffer can still accept a write when the head leaves this cycle.
   assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state is assigned with <= so every register samples
      // the pre-edge values, independent of statement order.
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: the storage is reset deliberately: the head word and PC must
      // read as zero straight after reset. It is only a few entries deep.
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_controller.sv
// -----------------------------------------------------------------------------
// instruction_fetch_controller
//   Owns the PC and drives a combinational instruction memory. Each returned
//   word is pushed, together with its PC, into a small FIFO. The FIFO head is
//   offered to decode over a valid/ready handshake. Redirects flush the FIFO.
//   A misaligned redirect target raises a sticky FAULT that only RST clears.
//   Ports:
//     CLK, RST          : clock; synchronous active-high reset
//     IMEM_ADDR         : memory address, always equal to the PC register
//     IMEM_DATA         : memory word for IMEM_ADDR, valid in the same cycle
//     INSTR_VALID/READY : decode handshake for the FIFO head
//     INSTR, INSTR_PC   : head instruction word and its PC
//     REDIRECT_VALID/PC : taken branch or jump and its target
//     HALT_REQ, RESUME  : stop fetching / restart fetching at the current PC
//     HALTED            : not running and FIFO empty
//     FAULT             : sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instruction_fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0,
   parameter int unsigned     PC_STEP  = 4,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            CLK,
   input  logic            RST,
   output logic [XLEN-1:0] IMEM_ADDR,
   input  logic [ILEN-1:0] IMEM_DATA,
   output logic            INSTR_VALID,
   input  logic            INSTR_READY,
   output logic [ILEN-1:0] INSTR,
   output logic [XLEN-1:0] INSTR_PC,
   input  logic            REDIRECT_VALID,
   input  logic [XLEN-1:0] REDIRECT_PC,
   input  logic            HALT_REQ,
   input  logic            RESUME,
   output logic            HALTED,
   output logic            FAULT
);

   localparam int unsigned   CW       = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_state_e  state_q;
   logic [XLEN-1:0] pc_q;
   logic            fault_q;
   logic [CW-1:0]   count;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;
   logic            pop;
   logic            fetch;

   assign INSTR_VALID = (count != '0);
   assign pop         = INSTR_VALID && INSTR_READY;

   // HALT_REQ blocks the fetch in the very cycle it is requested. A redirect
   // blocks it because the addressed word belongs to the discarded path.
   assign fetch = (state_q == ST_RUN) && !HALT_REQ && !REDIRECT_VALID &&
                  ((count != FULL_CNT) || pop);

   assign push_entry = '{instr: IMEM_DATA, pc: pc_q};

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (fetch),
      .pop_i   (pop),
      .flush_i (REDIRECT_VALID),
      .din_i   (push_entry),
      .dout_o  (head),
      .count_o (count)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q    <= RESET_PC;
         state_q <= ST_RUN;
         fault_q <= 1'b0;
      end else if (REDIRECT_VALID) begin
         // Redirects override halt/resume; an aligned target keeps the state.
         if (REDIRECT_PC[1:0] == 2'b00) begin
            pc_q <= REDIRECT_PC;
         end else begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT_HALT;
         end
      end else begin
         if (fetch) pc_q <= pc_q + XLEN'(PC_STEP);
         case (state_q)
            ST_RUN:  if (HALT_REQ) state_q <= ST_HALT;
            ST_HALT: if (RESUME && !HALT_REQ) state_q <= ST_RUN;
            default: state_q <= state_q;  // FAULT_HALT is left only by RST
         endcase
      end
   end

   assign IMEM_ADDR = pc_q;
   assign INSTR     = head.instr;
   assign INSTR_PC  = head.pc;
   assign HALTED    = (state_q != ST_RUN) && (count == '0);
   assign FAULT     = fault_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_controller
//   Self-checking bench. A combinational memory returns (addr/4)+1. A queue
//   model of the fetch stream predicts every output after each clock edge.
//   Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_controller;

   localparam logic [63:0] RESET_PC = 64'h0;
   localparam int          DEPTH    = 2;

   logic        clk;
   logic        rst;
   logic [63:0] imem_addr;
   logic [31:0] imem_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt_req;
   logic        resume;
   logic        halted;
   logic        fault;

   instruction_fetch_controller #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (4),
      .DEPTH    (DEPTH)
   ) dut (
      .CLK            (clk),
      .RST            (rst),
      .IMEM_ADDR      (imem_addr),
      .IMEM_DATA      (imem_data),
      .INSTR_VALID    (instr_valid),
      .INSTR_READY    (instr_ready),
      .INSTR          (instr),
      .INSTR_PC       (instr_pc),
      .REDIRECT_VALID (redirect_valid),
      .REDIRECT_PC    (redirect_pc),
      .HALT_REQ       (halt_req),
      .RESUME         (resume),
      .HALTED         (halted),
      .FAULT          (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: word i (address 4*i) holds i+1.
   function automatic logic [31:0] mem_word(input logic [63:0] addr);
      return 32'(addr >> 2) + 32'd1;
   endfunction

   assign imem_data = mem_word(imem_addr);

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } entry_t;

   entry_t      m_q[$];
   logic [63:0] m_pc;
   bit          m_stopped;  // not fetching (halted or faulted)
   bit          m_fault;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit rdy, input bit rv,
                             input logic [63:0] rpc, input bit hr, input bit rs);
      bit     do_pop;
      bit     do_fetch;
      entry_t e;
      if (r) begin
         m_pc      = RESET_PC;
         m_q       = {};
         m_stopped = 1'b0;
         m_fault   = 1'b0;
      end else begin
         do_pop = (m_q.size() != 0) && rdy;
         if (rv) begin
            m_q = {};
            if (rpc[1:0] == 2'b00) begin
               m_pc = rpc;
            end else begin
               m_fault   = 1'b1;
               m_stopped = 1'b1;
            end
         end else begin
            do_fetch = !m_stopped && !hr && ((m_q.size() < DEPTH) || do_pop);
            if (do_pop) void'(m_q.pop_front());
            if (do_fetch) begin
               e.instr = mem_word(m_pc);
               e.pc    = m_pc;
               m_q.push_back(e);
               m_pc = m_pc + 64'd4;
            end
            if (!m_stopped) begin
               if (hr) m_stopped = 1'b1;
            end else if (!m_fault && rs && !hr) begin
               m_stopped = 1'b0;
            end
         end
      end
   endtask

   task automatic check_all();
      check("imem_addr", imem_addr, m_pc);
      check("instr_valid", 64'(instr_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("instr", 64'(instr), 64'(m_q[0].instr));
         check("instr_pc", instr_pc, m_q[0].pc);
      end
      check("halted", 64'(halted), 64'(m_stopped && (m_q.size() == 0)));
      check("fault", 64'(fault), 64'(m_fault));
   endtask

   // Drive inputs for one clock, advance the model, then sample 1 ns after
   // the edge.
   task automatic cycle(input bit r, input bit rdy, input bit rv,
                        input logic [63:0] rpc, input bit hr, input bit rs);
      rst            = r;
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt_req       = hr;
      resume         = rs;
      model_step(r, rdy, rv, rpc, hr, rs);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0, 64'h0, 1'b0, 1'b0);
   endtask

   initial begin
      bit          r_rst;
      bit          r_rdy;
      bit          r_rv;
      bit          r_hr;
      bit          r_rs;
      logic [63:0] r_pc;
      int          sel;

      m_pc      = RESET_PC;
      m_stopped = 1'b0;
      m_fault   = 1'b0;

      // 1: reset, then streaming with READY high
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      check("rst_instr", 64'(instr), 64'h0);
      check("rst_instr_pc", instr_pc, 64'h0);
      idle(6, 1'b1);

      // 2: decode stalls, FIFO fills, then drains without gaps
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      idle(5, 1'b0);
      idle(4, 1'b1);

      // 3: redirect to 0x40 while the FIFO is full
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      idle(3, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 64'h40, 1'b0, 1'b0);
      idle(3, 1'b1);

      // 4: misaligned redirect faults; RESUME cannot leave it; RST does
      cycle(1'b0, 1'b1, 1'b1, 64'h42, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      idle(2, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      idle(2, 1'b1);

      // 5: halt at PC 0x10, drain, resume at the same PC
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      idle(4, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
      idle(4, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);  // HALT_REQ beats RESUME
      cycle(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      idle(5, 1'b1);

      // 6: reset with a full FIFO
      idle(3, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      check("rst6_valid", 64'(instr_valid), 64'h0);

      // redirect near the top of the address space, so the PC wraps
      cycle(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
      idle(4, 1'b1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(0, 49) == 0);
         r_rdy = ($urandom_range(0, 9) < 7);
         r_rv  = ($urandom_range(0, 15) == 0);
         r_hr  = ($urandom_range(0, 15) == 0);
         r_rs  = ($urandom_range(0, 7) == 0);
         sel   = $urandom_range(0, 15);
         if (sel == 0)     r_pc = {$urandom, $urandom};
         else if (sel < 4) r_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'(4 * $urandom_range(0, 3));
         else              r_pc = {$urandom, $urandom} & ~64'h3;
         cycle(r_rst, r_rdy, r_rv, r_pc, r_hr, r_rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
